// File: rtl/layer_sequencer.sv
// Per-layer control FSM for a fully connected layer: streams activation/weight
// addresses per neuron group, sequences accumulator clear/enable and write-back.
module layer_sequencer #(
  parameter int IN_LEN  = 784,
  parameter int OUT_LEN = 128,
  parameter int PAR     = 8,
  parameter int RD_LAT  = 1,
  localparam int NGRP = OUT_LEN / PAR,
  localparam int IAW  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int WAW  = (IN_LEN * NGRP > 1) ? $clog2(IN_LEN * NGRP) : 1,
  localparam int OAW  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           out_ready,
  output logic           busy,
  output logic           done,
  output logic [IAW-1:0] in_addr,
  output logic [WAW-1:0] w_addr,
  output logic           acc_clr,
  output logic           mac_en,
  output logic           mac_last,
  output logic           out_we,
  output logic [OAW-1:0] out_addr
);

  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IAW-1:0] I_LAST = IAW'(IN_LEN - 1);
  localparam logic [GW-1:0]  G_LAST = GW'(NGRP - 1);
  localparam logic [1:0]     D_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [GW-1:0]     grp;
  logic [1:0]        drain_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    acc_clr    = (state == S_CLEAR);
    out_we     = (state == S_WRITE);
    done       = (state == S_DONE);
    unique case (state)
      S_IDLE:   if (start) state_next = S_CLEAR;
      S_CLEAR:  state_next = S_STREAM;
      S_STREAM: if (in_addr == I_LAST) state_next = S_DRAIN;
      S_DRAIN:  if (drain_cnt == D_LAST) state_next = S_WRITE;
      S_WRITE:  if (out_ready) state_next = (grp == G_LAST) ? S_DONE : S_CLEAR;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // in_addr doubles as the element index i; w_addr runs on its own counter and
  // only steps between elements, so both hold their last issued value outside STREAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp       <= '0;
      drain_cnt <= '0;
      in_addr   <= '0;
      w_addr    <= '0;
      out_addr  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            grp      <= '0;
            w_addr   <= '0;
            out_addr <= '0;
          end
        end
        S_CLEAR: begin
          in_addr   <= '0;
          drain_cnt <= '0;
          if (grp != '0) w_addr <= w_addr + WAW'(1);
        end
        S_STREAM: begin
          if (in_addr != I_LAST) begin
            in_addr <= in_addr + IAW'(1);
            w_addr  <= w_addr + WAW'(1);
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + 2'd1;
        S_WRITE: begin
          if (out_ready && grp != G_LAST) begin
            grp      <= grp + GW'(1);
            out_addr <= out_addr + OAW'(PAR);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the read-valid pipe is reset, so an aborted run cannot leak mac_en
  // pulses out of the pipe after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= (state == S_STREAM);
      last_pipe[0] <= (state == S_STREAM) && (in_addr == I_LAST);
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
    end
  end

  assign mac_en   = vld_pipe[RD_LAT-1];
  assign mac_last = last_pipe[RD_LAT-1];

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: two small configs checked cycle by
// cycle against a timeline model, plus one full-size default run.
module tb_layer_sequencer;

  localparam int S_IN  = 4;
  localparam int S_PAR = 4;
  localparam int S_GRP = 2;
  localparam int NE    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instances share rst; start/out_ready routed by sel
  logic rst_s = 1'b1, start_s = 1'b0, rdy_s = 1'b0;
  int   sel = 0;
  logic start_a, rdy_a, start_c, rdy_c;
  assign start_a = (sel == 0) ? start_s : 1'b0;
  assign rdy_a   = (sel == 0) ? rdy_s   : 1'b0;
  assign start_c = (sel == 1) ? start_s : 1'b0;
  assign rdy_c   = (sel == 1) ? rdy_s   : 1'b0;

  logic       busy_a, done_a, clr_a, mac_a, last_a, we_a;
  logic [1:0] in_a;
  logic [2:0] w_a, oa_a;
  logic       busy_c, done_c, clr_c, mac_c, last_c, we_c;
  logic [1:0] in_c;
  logic [2:0] w_c, oa_c;

  layer_sequencer #(.IN_LEN(S_IN), .OUT_LEN(8), .PAR(S_PAR), .RD_LAT(1)) u_sm1 (
    .clk(clk), .rst(rst_s), .start(start_a), .out_ready(rdy_a),
    .busy(busy_a), .done(done_a), .in_addr(in_a), .w_addr(w_a),
    .acc_clr(clr_a), .mac_en(mac_a), .mac_last(last_a),
    .out_we(we_a), .out_addr(oa_a)
  );

  layer_sequencer #(.IN_LEN(S_IN), .OUT_LEN(8), .PAR(S_PAR), .RD_LAT(3)) u_sm3 (
    .clk(clk), .rst(rst_s), .start(start_c), .out_ready(rdy_c),
    .busy(busy_c), .done(done_c), .in_addr(in_c), .w_addr(w_c),
    .acc_clr(clr_c), .mac_en(mac_c), .mac_last(last_c),
    .out_we(we_c), .out_addr(oa_c)
  );

  logic        rst_b = 1'b1, start_b = 1'b0, rdy_b = 1'b1;
  logic        busy_b, done_b, clr_b, mac_b, last_b, we_b;
  logic [9:0]  in_b;
  logic [13:0] w_b;
  logic [6:0]  oa_b;

  layer_sequencer u_big (
    .clk(clk), .rst(rst_b), .start(start_b), .out_ready(rdy_b),
    .busy(busy_b), .done(done_b), .in_addr(in_b), .w_addr(w_b),
    .acc_clr(clr_b), .mac_en(mac_b), .mac_last(last_b),
    .out_we(we_b), .out_addr(oa_b)
  );

  // {busy, done, acc_clr, mac_en, mac_last, out_we, in_addr, w_addr, out_addr}
  logic [13:0] obs;
  always_comb begin
    if (sel == 1) obs = {busy_c, done_c, clr_c, mac_c, last_c, we_c, in_c, w_c, oa_c};
    else          obs = {busy_a, done_a, clr_a, mac_a, last_a, we_a, in_a, w_a, oa_a};
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [13:0] e_vec [0:NE-1];
  bit          e_rdy [0:NE-1];
  int          m_in [2];
  int          m_w  [2];
  int          m_oa [2];

  // Timeline model: lays out each group as CLEAR, IN_LEN stream cycles,
  // RD_LAT drain cycles and a WRITE window of (stall+1) cycles, placing every
  // expected event by arithmetic; addresses hold between their set points.
  task automatic build_model(input int which, input int st0, input int st1,
                             output int len, output int s_poke, output int w_poke,
                             output int a_d);
    int rd, c, ws;
    int st [2];
    int ia [NE]; int wa [NE]; int oa [NE];
    bit clr [NE]; bit mac [NE]; bit lst [NE]; bit we [NE]; bit bz [NE]; bit dn [NE];
    int cur_in, cur_w, cur_oa;
    rd = (which == 0) ? 1 : 3;
    st[0] = st0;
    st[1] = st1;
    s_poke = 0; w_poke = 0; a_d = 0;
    for (int d = 0; d < NE; d++) begin
      ia[d] = -1; wa[d] = -1; oa[d] = -1;
      clr[d] = 0; mac[d] = 0; lst[d] = 0; we[d] = 0; bz[d] = 0; dn[d] = 0;
      e_rdy[d] = 1'($urandom_range(0, 1));
    end
    c = 1;
    wa[1] = 0;
    for (int g = 0; g < S_GRP; g++) begin
      clr[c] = 1;
      oa[c]  = g * S_PAR;
      for (int i = 0; i < S_IN; i++) begin
        ia[c+1+i]     = i;
        wa[c+1+i]     = g * S_IN + i;
        mac[c+1+rd+i] = 1;
        lst[c+1+rd+i] = (i == S_IN - 1);
      end
      ws = c + 1 + S_IN + rd;
      if (g == 0) begin
        s_poke = c + 1 + $urandom_range(0, S_IN - 1);
        w_poke = ws + $urandom_range(0, st[g]);
      end else begin
        a_d = c + 1 + 2;
      end
      for (int k = 0; k <= st[g]; k++) begin
        we[ws+k]    = 1;
        e_rdy[ws+k] = (k == st[g]);
      end
      c = ws + st[g] + 1;
    end
    dn[c] = 1;
    len   = c;
    for (int d = 1; d <= c; d++) bz[d] = 1;
    cur_in = m_in[which]; cur_w = m_w[which]; cur_oa = m_oa[which];
    for (int d = 0; d < NE; d++) begin
      if (ia[d] >= 0) cur_in = ia[d];
      if (wa[d] >= 0) cur_w  = wa[d];
      if (oa[d] >= 0) cur_oa = oa[d];
      e_vec[d] = {bz[d], dn[d], clr[d], mac[d], lst[d], we[d],
                  2'(cur_in), 3'(cur_w), 3'(cur_oa)};
    end
    m_in[which] = cur_in; m_w[which] = cur_w; m_oa[which] = cur_oa;
  endtask

  // One small-config run; entered and left #1 after a rising edge.
  task automatic run_small(input int which, input int st0, input int st1,
                           input bit poke, input bit abort,
                           output int done_d, output int len);
    int s_poke, w_poke, a_d, last;
    logic [13:0] exp_v;
    build_model(which, st0, st1, len, s_poke, w_poke, a_d);
    sel    = which;
    last   = abort ? a_d + 4 : len + 3;
    done_d = -1;
    start_s = 1'b1;
    rdy_s   = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0;
    rdy_s   = e_rdy[1];
    for (int d = 1; d <= last; d++) begin
      @(negedge clk);
      exp_v = (abort && d > a_d) ? 14'd0 : e_vec[d];
      n_total++;
      if (obs !== exp_v)
        $display("FAIL timeline cfg=%0d stall=%0d/%0d cycle=%0d got=%h want=%h",
                 which, st0, st1, d, obs, exp_v);
      else n_pass++;
      if (obs[12] === 1'b1 && done_d < 0) done_d = d;
      @(posedge clk); #1;
      rdy_s   = e_rdy[d+1];
      start_s = poke && (d + 1 == s_poke || d + 1 == w_poke);
      rst_s   = abort && (d + 1 == a_d);
    end
    start_s = 1'b0;
    rst_s   = 1'b0;
    if (abort) begin
      for (int k = 0; k < 2; k++) begin
        m_in[k] = 0; m_w[k] = 0; m_oa[k] = 0;
      end
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_s = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k;
      @(negedge clk);
      n_total++;
      if (obs !== 14'd0) $display("FAIL reset_small cfg=%0d got=%h want=0", k, obs);
      else n_pass++;
    end
    n_total++;
    if ({busy_b, done_b, clr_b, mac_b, last_b, we_b, in_b, w_b, oa_b} !== '0)
      $display("FAIL reset_big got busy=%b done=%b clr=%b mac=%b we=%b in=%0d w=%0d oa=%0d want all 0",
               busy_b, done_b, clr_b, mac_b, we_b, in_b, w_b, oa_b);
    else n_pass++;
    @(posedge clk); #1;
    rst_s = 1'b0; rst_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 0; m_w[k] = 0; m_oa[k] = 0;
    end
    idle_gap(2);
  endtask

  task automatic check_done(input string name, input int got, input int want);
    n_total++;
    if (got !== want) $display("FAIL %s done_cycle got=%0d want=%0d", name, got, want);
    else n_pass++;
  endtask

  task automatic test_basic;
    int dd, len;
    run_small(0, 0, 0, 1'b0, 1'b0, dd, len);
    check_done("basic", dd, 15);
    idle_gap(2);
  endtask

  task automatic test_backpressure;
    int dd, len;
    run_small(0, 3, 3, 1'b0, 1'b0, dd, len);
    check_done("backpressure", dd, 21);
    idle_gap(1);
  endtask

  task automatic test_start_while_busy;
    int dd, len;
    run_small(0, 1, 0, 1'b1, 1'b0, dd, len);
    check_done("start_busy", dd, 16);
    idle_gap(1);
  endtask

  task automatic test_reset_mid_stream;
    int dd, len;
    run_small(0, 0, 0, 1'b0, 1'b1, dd, len);
    check_done("abort_no_done", dd, -1);
    idle_gap(2);
    run_small(0, 0, 0, 1'b0, 1'b0, dd, len);
    check_done("after_abort", dd, 15);
    idle_gap(1);
  endtask

  task automatic test_latency;
    int dd, len;
    run_small(1, 0, 0, 1'b0, 1'b0, dd, len);
    check_done("rd_lat3", dd, 19);
    idle_gap(1);
  endtask

  task automatic test_random;
    int dd, len, which;
    for (int it = 0; it < 8; it++) begin
      which = $urandom_range(0, 1);
      run_small(which, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0, dd, len);
      check_done("random", dd, len);
      idle_gap($urandom_range(0, 3));
    end
  endtask

  task automatic test_default_run;
    int macs, hs, overlap, done_d;
    macs = 0; hs = 0; overlap = 0; done_d = -1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int d = 1; d <= 13000; d++) begin
      @(negedge clk);
      if (d == 1) begin
        n_total++;
        if (!(clr_b === 1'b1 && busy_b === 1'b1))
          $display("FAIL big_start_latency got clr=%b busy=%b want 1 1", clr_b, busy_b);
        else n_pass++;
      end
      if (mac_b === 1'b1) macs++;
      if (mac_b === 1'b1 && clr_b === 1'b1) overlap++;
      if (we_b === 1'b1 && rdy_b === 1'b1) begin
        n_total++;
        if (oa_b !== 7'(hs * 8))
          $display("FAIL big_out_addr handshake=%0d got=%0d want=%0d", hs, oa_b, hs * 8);
        else n_pass++;
        hs++;
      end
      if (done_b === 1'b1 && done_d < 0) begin
        done_d = d;
        n_total++;
        if (w_b !== 14'd12543) $display("FAIL big_final_w_addr got=%0d want=12543", w_b);
        else n_pass++;
      end else if (done_d > 0) begin
        n_total++;
        if (done_b !== 1'b0 || busy_b !== 1'b0)
          $display("FAIL big_done_pulse got done=%b busy=%b want 0 0", done_b, busy_b);
        else n_pass++;
        break;
      end
    end
    check_done("big", done_d, 12593);
    n_total++;
    if (macs !== 12544) $display("FAIL big_mac_count got=%0d want=12544", macs);
    else n_pass++;
    n_total++;
    if (hs !== 16) $display("FAIL big_handshakes got=%0d want=16", hs);
    else n_pass++;
    n_total++;
    if (overlap !== 0) $display("FAIL big_clr_mac_overlap got=%0d want=0", overlap);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_stream();
    test_latency();
    test_random();
    test_default_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Per-layer control FSM that drives one fully connected layer's shared MAC array. It walks the layer's input activations and weight ROM in lock-step, clearing and enabling PAR parallel accumulators per neuron group. After each group it requests a write-back of the group's PAR results, and pulses `done` when all OUT_LEN neurons are written. One instance sits under the global controller per layer: the controller's `lN_run` feeds `start` and `done` feeds `lN_done`.

## Interface
- `IN_LEN`, 784: inputs per neuron (input activation count).
- `OUT_LEN`, 128: neurons in the layer. Must be a multiple of `PAR`.
- `PAR`, 8: neurons computed concurrently (accumulator count).
- `RD_LAT`, 1: read latency of input buffer and weight ROM, in cycles. Legal range 1..4.
- Derived constants: `NGRP = OUT_LEN/PAR`, `IAW = clog2(IN_LEN)`, `WAW = clog2(IN_LEN*NGRP)`, `OAW = clog2(OUT_LEN)`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled in IDLE only; ignored in all other states.
- `out_ready`  in  1  write-back sink accepts the group result.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final group write is accepted.
- `in_addr`  out  IAW  input activation read address.
- `w_addr`  out  WAW  weight ROM read address; equals group*IN_LEN + i.
- `acc_clr`  out  1  clear all PAR accumulators.
- `mac_en`  out  1  operands at the memory outputs are valid this cycle; accumulate.
- `mac_last`  out  1  coincides with the final `mac_en` of a group.
- `out_we`  out  1  write-back request for the current group.
- `out_addr`  out  OAW  base neuron index of the group, group*PAR.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, WRITE, DONE.
- **IDLE:** if `start`=1, clear the group counter and `w_addr`, then go to CLEAR.
- **CLEAR:** drive `acc_clr`=1 for exactly one cycle, set i=0, then go to STREAM.
- **STREAM:** drive `in_addr`=i and `w_addr` for one cycle per element, for i=0..IN_LEN-1.
  - `w_addr` comes from its own incrementing counter. No multiplier.
  - `w_addr` is not reset between groups; it runs 0..IN_LEN*NGRP-1 continuously.
  - After issuing i=IN_LEN-1, go to DRAIN.
- **Read-valid pipe:** an RD_LAT-deep shift register.
  - Its input is 1 on every STREAM cycle; its output is `mac_en`.
  - `mac_last` is the same pipe carrying (i==IN_LEN-1).
- **DRAIN:** stay exactly RD_LAT cycles while the pipe empties, then go to WRITE.
- **WRITE:** hold `out_we`=1 and `out_addr`=group*PAR until `out_we && out_ready`.
  - On that handshake: if group==NGRP-1, go to DONE; otherwise increment group and go to CLEAR.
- **DONE:** `done`=1 for one cycle, then go to IDLE. If `start` is still high, a new run begins from IDLE.
- **Address hold:** outside STREAM, `in_addr` and `w_addr` hold their last values. `out_addr` is updated only on group change.
- **Reset values:** all outputs 0, state IDLE, counters 0, read-valid pipe cleared.
- **Reset mid-run:** abort immediately with no `done` and no further `mac_en`. Pipe contents are discarded.

## Timing
- **Start latency:** `start` sampled at edge k gives `acc_clr`=1 and `busy`=1 in cycle k+1.
- **First operand:** first STREAM cycle is k+2; first `mac_en` is k+2+RD_LAT.
- **Per-group cycles:** 1 (CLEAR) + IN_LEN + RD_LAT + W, where W ≥ 1 is the WRITE stall length.
- **Whole layer:** `done` fires NGRP·(IN_LEN+RD_LAT+2) cycles after the start edge with `out_ready` tied 1. Defaults give 16·787 = 12592; `done` falls in cycle k+12593.
- **Throughput:** `mac_en` is high for exactly IN_LEN consecutive cycles per group, with no bubbles.
- **Ordering:** `acc_clr` never overlaps `mac_en`. `out_we` rises on the cycle after the last `mac_en`.
- **Backpressure:** `out_ready` low stalls only WRITE. No address or `mac_en` activity occurs while stalled.

## Test plan
- **Small config, basic run.** IN_LEN=4, OUT_LEN=8, PAR=4, RD_LAT=1, `start` pulse at edge 0. Required:
  - `acc_clr` in cycles 1 and 8; `in_addr` 0,1,2,3 in cycles 2-5; `mac_en` cycles 3-6 with `mac_last` in cycle 6.
  - `out_we` cycle 7 with `out_addr`=0, then cycle 14 with `out_addr`=4.
  - `w_addr` 0..7 across both groups; `done` in cycle 15.
- **Default config, full run.** `start` at edge k, `out_ready`=1. Required:
  - Exactly 12544 `mac_en` cycles and 16 `out_we` handshakes, with `out_addr` 0,8,…,120.
  - Final `w_addr`=12543; `done` in cycle k+12593.
- **Backpressure.** Small config with `out_ready`=0 for 3 cycles at each WRITE. Required:
  - `out_we` and `out_addr` held stable for 4 cycles; no `mac_en` during the stall.
  - `done` delayed by exactly 6 cycles (cycle 21).
- **Start while busy.** Pulse `start` during STREAM and during WRITE. Required: no restart and no counter perturbation; `done` is still a single pulse at the nominal cycle.
- **Reset mid-STREAM.** Assert `rst` at i=2 of group 1. Required:
  - Next cycle all outputs are 0 and `busy`=0; no `mac_en` emerges from the pipe.
  - A subsequent `start` reproduces the basic-run timing exactly.
- **Latency variant.** RD_LAT=3, small config. Required:
  - `mac_en` in cycles 5-8; DRAIN lasts 3 cycles; `out_we` in cycle 9.
  - `done` in cycle 19, i.e. 2·(4+3+2)+1.
